fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the execute stage.
- Holds the fetch PC, issues single-outstanding requests to instruction memory, and buffers returned words with their PCs in a small FIFO.
- Presents {inst, inst_pc} to downstream with a valid/ready handshake.
- Taken branches from execute (Branch/BrPC) arrive as a redirect, which flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory port, the execute redirect and the downstream instruction port.
interface fetch_stage_if;
    import fetch_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid (imem_req / inst_valid)
    // and ready (imem_ready / inst_ready) are both 1; address and payload hold while valid && !ready.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {inst, pc} entries; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output fetch_entry_t     o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only visible through r_count.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding memory requests, buffered responses, branch redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                PC_STEP    = 4,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fs,
    output fetch_state_t  o_dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;
    logic              w_req;
    logic              w_inst_valid;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_REQ;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (!fs.redirect && w_accept) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (fs.imem_rvalid)      w_next_state = S_REQ;
                else if (fs.redirect)    w_next_state = S_DISCARD;
            end
            S_DISCARD: begin
                if (fs.imem_rvalid) w_next_state = S_REQ;
            end
            default: w_next_state = S_REQ;
        endcase
    end

    // A request is only issued with a free FIFO slot, which reserves room for its response.
    always_comb begin
        w_req        = (r_state == S_REQ) && (w_count < CNT_W'(FIFO_DEPTH)) && !fs.redirect && !rst;
        w_inst_valid = (w_count != '0) && !fs.redirect && !rst;
    end

    assign w_accept    = w_req && fs.imem_ready;
    assign w_push      = (r_state == S_WAIT) && fs.imem_rvalid && !fs.redirect;
    assign w_pop       = w_inst_valid && fs.inst_ready;
    assign w_push_data = '{inst: fs.imem_rdata, pc: r_req_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (fs.redirect) begin
            r_pc <= fs.redirect_pc;
        end else if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + ADDR_W'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (fs.redirect),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign fs.imem_req   = w_req;
    assign fs.imem_addr  = r_pc;
    assign fs.inst_valid = w_inst_valid;
    assign fs.inst       = rst ? '0 : w_head.inst;
    assign fs.inst_pc    = rst ? '0 : w_head.pc;
    assign o_dbg_state   = r_state;

    // A response with nothing outstanding means the memory broke the protocol.
    a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (rst)
        !((r_state == S_REQ) && fs.imem_rvalid));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction-memory responder.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    fetch_state_t dbg_state;
    fetch_stage_if fs();

    int          checks   = 0;
    int          failures = 0;
    bit          pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          mem_lat  = 1;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .PC_STEP    (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fs          (fs),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: sample the request side at negedge, then model memory after the edge.
    task automatic cyc();
        logic        acc;
        logic        rv;
        logic [31:0] addr;
        @(negedge clk);
        acc  = fs.imem_req && fs.imem_ready;
        rv   = fs.imem_rvalid;
        addr = fs.imem_addr;
        @(posedge clk);
        #1;
        if (rv) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = addr;
            pend_cnt  = mem_lat;
        end
        fs.imem_rvalid = 1'b0;
        fs.imem_rdata  = '0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                fs.imem_rvalid = 1'b1;
                fs.imem_rdata  = 32'hC0DE_0000 | {16'h0000, pend_addr[15:0]};
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst            = 1'b1;
        pend           = 1'b0;
        fs.imem_rvalid = 1'b0;
        fs.imem_rdata  = '0;
        settle();
        chk({tag, "_rst_req"},    32'(fs.imem_req),   32'd0);
        chk({tag, "_rst_valid"},  32'(fs.inst_valid), 32'd0);
        chk({tag, "_rst_inst"},   fs.inst,            32'd0);
        chk({tag, "_rst_instpc"}, fs.inst_pc,         32'd0);
        cyc();
        rst = 1'b0;
    endtask

    task automatic exp_inst(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, 32'(fs.inst_valid), 32'(v));
        chk({tag, "_pc"},    fs.inst_pc,         pc);
        chk({tag, "_inst"},  fs.inst,            ins);
    endtask

    task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"},  32'(fs.imem_req), 32'(req));
        chk({tag, "_addr"}, fs.imem_addr,     addr);
    endtask

    initial begin
        rst            = 1'b1;
        fs.imem_ready  = 1'b1;
        fs.imem_rvalid = 1'b0;
        fs.imem_rdata  = '0;
        fs.redirect    = 1'b0;
        fs.redirect_pc = '0;
        fs.inst_ready  = 1'b1;

        // Free-running memory, downstream always ready.
        do_reset("t1");
        settle();
        exp_req("t1_first", 1'b1, 32'h0);
        chk("t1_state0", 32'(dbg_state), 32'(S_REQ));
        cyc(); settle();
        chk("t1_wait_req", 32'(fs.imem_req), 32'd0);
        chk("t1_state1", 32'(dbg_state), 32'(S_WAIT));
        cyc(); settle();
        exp_inst("t1_i0", 1'b1, 32'h0, 32'hC0DE_0000);
        exp_req("t1_r1", 1'b1, 32'h4);
        cyc(); settle();
        chk("t1_gap_valid", 32'(fs.inst_valid), 32'd0);
        cyc(); settle();
        exp_inst("t1_i1", 1'b1, 32'h4, 32'hC0DE_0004);
        exp_req("t1_r2", 1'b1, 32'h8);
        cyc(); cyc(); settle();
        exp_inst("t1_i2", 1'b1, 32'h8, 32'hC0DE_0008);

        // Downstream stalled: FIFO fills, requests stop, then drains in order.
        fs.inst_ready = 1'b0;
        do_reset("t2");
        settle();
        cyc(); cyc(); settle();
        exp_req("t2_r1", 1'b1, 32'h4);
        exp_inst("t2_h0", 1'b1, 32'h0, 32'hC0DE_0000);
        cyc(); cyc(); settle();
        chk("t2_full_req", 32'(fs.imem_req), 32'd0);
        cyc(); cyc(); settle();
        exp_req("t2_hold", 1'b0, 32'h8);
        exp_inst("t2_hold_head", 1'b1, 32'h0, 32'hC0DE_0000);
        fs.inst_ready = 1'b1;
        settle();
        cyc(); settle();
        exp_inst("t2_h1", 1'b1, 32'h4, 32'hC0DE_0004);
        exp_req("t2_resume", 1'b1, 32'h8);
        cyc(); settle();
        chk("t2_empty_valid", 32'(fs.inst_valid), 32'd0);
        cyc(); settle();
        exp_inst("t2_h2", 1'b1, 32'h8, 32'hC0DE_0008);

        // Redirect while waiting on a slow response: stale word is dropped.
        fs.inst_ready = 1'b1;
        mem_lat = 3;
        do_reset("t3");
        settle();
        exp_req("t3_r0", 1'b1, 32'h0);
        cyc();
        fs.redirect    = 1'b1;
        fs.redirect_pc = 32'h0000_0100;
        settle();
        chk("t3_redir_req", 32'(fs.imem_req), 32'd0);
        cyc();
        fs.redirect = 1'b0;
        mem_lat = 1;
        settle();
        chk("t3_discard", 32'(dbg_state), 32'(S_DISCARD));
        chk("t3_disc_req", 32'(fs.imem_req), 32'd0);
        cyc(); settle();
        chk("t3_stale_rv", 32'(fs.imem_rvalid), 32'd1);
        chk("t3_stale_valid", 32'(fs.inst_valid), 32'd0);
        cyc(); settle();
        exp_inst("t3_dropped", 1'b0, 32'h0, 32'h0);
        exp_req("t3_target", 1'b1, 32'h0000_0100);
        cyc(); cyc(); settle();
        exp_inst("t3_i0", 1'b1, 32'h0000_0100, 32'hC0DE_0100);

        // Redirect coinciding with a response and a pop attempt.
        fs.inst_ready = 1'b0;
        do_reset("t4");
        settle();
        cyc(); cyc(); cyc();
        fs.redirect    = 1'b1;
        fs.redirect_pc = 32'h0000_0200;
        fs.inst_ready  = 1'b1;
        settle();
        chk("t4_state", 32'(dbg_state), 32'(S_WAIT));
        chk("t4_rv", 32'(fs.imem_rvalid), 32'd1);
        chk("t4_redir_valid", 32'(fs.inst_valid), 32'd0);
        cyc();
        fs.redirect = 1'b0;
        settle();
        exp_inst("t4_flushed", 1'b0, 32'h0, 32'h0);
        exp_req("t4_target", 1'b1, 32'h0000_0200);
        chk("t4_state2", 32'(dbg_state), 32'(S_REQ));
        cyc(); cyc(); settle();
        exp_inst("t4_i0", 1'b1, 32'h0000_0200, 32'hC0DE_0200);

        // Back-to-back redirects, last wins, then PC wraps past the top.
        fs.inst_ready = 1'b1;
        do_reset("t5");
        fs.redirect    = 1'b1;
        fs.redirect_pc = 32'h0000_0300;
        settle();
        chk("t5_redir_req", 32'(fs.imem_req), 32'd0);
        cyc();
        fs.redirect_pc = 32'hFFFF_FFFC;
        cyc();
        fs.redirect = 1'b0;
        settle();
        exp_req("t5_top", 1'b1, 32'hFFFF_FFFC);
        cyc(); cyc(); settle();
        exp_inst("t5_i0", 1'b1, 32'hFFFF_FFFC, 32'hC0DE_FFFC);
        exp_req("t5_wrap", 1'b1, 32'h0);
        cyc(); cyc(); settle();
        exp_inst("t5_i1", 1'b1, 32'h0, 32'hC0DE_0000);

        // Reset mid-flight with a buffered entry and a response pending.
        fs.inst_ready = 1'b0;
        do_reset("t6a");
        settle();
        cyc(); cyc(); cyc(); settle();
        chk("t6_pre_state", 32'(dbg_state), 32'(S_WAIT));
        chk("t6_pre_valid", 32'(fs.inst_valid), 32'd1);
        do_reset("t6b");
        settle();
        chk("t6_valid", 32'(fs.inst_valid), 32'd0);
        exp_req("t6_restart", 1'b1, 32'h0);
        chk("t6_state", 32'(dbg_state), 32'(S_REQ));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
